// File: rtl/prbs31_pkg.sv
// prbs31_pkg: shared states, taps, thresholds and status layout for the PRBS31 tiles
package prbs31_pkg;
  typedef enum logic [1:0] {
    ST_FILL   = 2'b00,
    ST_HUNT   = 2'b01,
    ST_LOCKED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;
  localparam int DEF_LOCK_RUN = 64;
  localparam int DEF_LOS_WINDOW = 256;
  localparam int DEF_LOS_ERRORS = 16;
  localparam logic [23:0] ERR_MAX = 24'hFF_FFFF;
  function automatic logic [7:0] status_byte(input logic sat, input state_t st);
    return {5'b0, sat, st};
  endfunction
endpackage

// File: rtl/prbs31_checker_if.sv
// prbs31_checker_if: Tiny Tapeout tile pins; master drives ui_in/uio_in/ena, slave drives uo_out/uio_out/uio_oe
interface prbs31_checker_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  modport master(output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave(input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/prbs31_lfsr.sv
// prbs31_lfsr: 31-bit x^31+x^28+1 shift register; adv shifts in ext_bit or, with use_pred, the predicted bit pred
module prbs31_lfsr
  import prbs31_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv,
  input  logic        use_pred,
  input  logic        ext_bit,
  output logic [30:0] s,
  output logic        pred
);
  assign pred = s[TAP_HI] ^ s[TAP_LO];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else if (adv) s <= {s[29:0], use_pred ? pred : ext_bit};
endmodule

// File: rtl/tt_um_parikshith2901_prbs31_checker.sv
// tt_um_parikshith2901_prbs31_checker: self-syncing PRBS31 checker; clk, rst_n (async low), tt = tile pins (ui_in rx/valid/clear/sel, uo_out byte mux, uio_out locked/err_pulse/sat)
module tt_um_parikshith2901_prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_RUN   = DEF_LOCK_RUN,
  parameter int LOS_WINDOW = DEF_LOS_WINDOW,
  parameter int LOS_ERRORS = DEF_LOS_ERRORS
) (
  input logic clk,
  input logic rst_n,
  prbs31_checker_if.slave tt
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int WW = $clog2(LOS_WINDOW + 1);
  localparam int EW = $clog2(LOS_ERRORS + 1);
  logic rx, valid, clr, pred, mismatch, pulse_d, locked_q, pulse_q, sat_q;
  logic [1:0] sel;
  logic [30:0] s;
  state_t state_q, state_d;
  logic [4:0] fill_q, fill_d;
  logic [RW-1:0] run_q, run_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] werr_q, werr_d;
  logic [23:0] err_q, err_d;
  logic unused_ok;
  assign rx = tt.ui_in[0];
  assign valid = tt.ui_in[1];
  assign clr = tt.ui_in[2];
  assign sel = tt.ui_in[4:3];
  assign unused_ok = &{1'b0, tt.ena, tt.uio_in, tt.ui_in[7:5]};
  assign mismatch = rx != pred;
  // Once locked the register flywheels on its own prediction so a bad rx bit cannot corrupt later predictions.
  prbs31_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (valid),
    .use_pred(state_q == ST_LOCKED),
    .ext_bit (rx),
    .s       (s),
    .pred    (pred)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ST_FILL;
      fill_q   <= '0;
      run_q    <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      run_q    <= run_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      err_q    <= err_d;
      locked_q <= state_d == ST_LOCKED;
      pulse_q  <= pulse_d;
      sat_q    <= err_d == ERR_MAX;
    end
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    run_d   = run_q;
    win_d   = win_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    if (valid)
      case (state_q)
        ST_HUNT: begin
          // an all-zero register predicts zeros forever, so it never counts toward lock
          run_d = (mismatch || s == '0) ? '0 : run_q + 1'b1;
          if (!mismatch && s != '0 && run_q == RW'(LOCK_RUN - 1)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end
        end
        ST_LOCKED: begin
          pulse_d = mismatch;
          werr_d  = werr_q + EW'(mismatch);
          win_d   = win_q + 1'b1;
          if (werr_d == EW'(LOS_ERRORS)) begin
            state_d = ST_FILL;
            fill_d  = '0;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_d == WW'(LOS_WINDOW)) begin
            win_d  = '0;
            werr_d = '0;
          end
        end
        default: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == 5'd30) begin
            state_d = ST_HUNT;
            fill_d  = '0;
            run_d   = '0;
          end
        end
      endcase
  end
  assign err_d = clr ? '0 : (pulse_d && err_q != ERR_MAX) ? err_q + 1'b1 : err_q;
  assign tt.uo_out = sel == 2'b00 ? err_q[7:0] :
                     sel == 2'b01 ? err_q[15:8] :
                     sel == 2'b10 ? err_q[23:16] : status_byte(sat_q, state_q);
  assign tt.uio_out = {5'b0, sat_q, pulse_q, locked_q};
  assign tt.uio_oe = 8'h07;
endmodule

// File: tb/tb_tt_um_parikshith2901_prbs31_checker.sv
// tb_tt_um_parikshith2901_prbs31_checker: directed table + sequence bench for the PRBS31 checker tile
module tb_tt_um_parikshith2901_prbs31_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [30:0] gs = 31'h7FFF_FFFF;
  prbs31_checker_if tt();
  tt_um_parikshith2901_prbs31_checker dut (.clk(clk), .rst_n(rst_n), .tt(tt));
  always #5 clk = ~clk;
  typedef struct {
    logic v, inv, clr;
    logic [1:0] sel;
    logic [7:0] exp_uo;
    logic exp_lock, exp_pulse;
  } vec_t;
  vec_t vt[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic next_bit(output logic b);
    b = gs[30] ^ gs[27];
    gs = {gs[29:0], b};
  endtask
  task automatic drive(input logic v, input logic b, input logic c, input logic [1:0] sel);
    tt.ui_in = {3'b0, sel, c, v, b};
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic v, input logic inv, input logic c, input logic [1:0] sel);
    logic b;
    b = 1'b0;
    if (v) begin
      next_bit(b);
      b = b ^ inv;
    end
    drive(v, b, c, sel);
  endtask
  task automatic rd(input logic [1:0] sel, output logic [7:0] d);
    @(negedge clk);
    tt.ui_in = {3'b0, sel, 3'b000};
    #1 d = tt.uo_out;
  endtask
  task automatic rd_err(output logic [23:0] e);
    logic [7:0] d;
    rd(2'd0, d); e[7:0] = d;
    rd(2'd1, d); e[15:8] = d;
    rd(2'd2, d); e[23:16] = d;
  endtask
  task automatic do_reset();
    tt.ui_in = 8'h18;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic lock_clean(input string nm);
    for (int i = 1; i <= 95; i++) begin
      send(1, 0, 0, 0);
      if (i == 94) chk({nm, "_pre_lock"}, tt.uio_out[0], 1'b0);
      if (i == 95) chk({nm, "_lock"}, tt.uio_out[0], 1'b1);
    end
  endtask
  initial begin
    logic [7:0] d;
    logic [23:0] e;
    logic bad;
    int nerr;
    vt[0] = '{0, 0, 0, 2'd0, 8'h01, 1, 0};
    vt[1] = '{0, 0, 0, 2'd1, 8'h00, 1, 0};
    vt[2] = '{0, 0, 0, 2'd3, 8'h02, 1, 0};
    vt[3] = '{1, 1, 0, 2'd0, 8'h02, 1, 1};
    vt[4] = '{0, 0, 1, 2'd0, 8'h00, 1, 0};
    vt[5] = '{1, 1, 1, 2'd0, 8'h00, 1, 1};
    vt[6] = '{1, 0, 0, 2'd0, 8'h00, 1, 0};
    vt[7] = '{1, 1, 0, 2'd0, 8'h01, 1, 1};
    vt[8] = '{0, 0, 0, 2'd3, 8'h02, 1, 0};
    tt.ena = 1'b1;
    tt.uio_in = 8'h00;
    tt.ui_in = 8'h1B;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo", tt.uo_out, 8'h00);
    chk("rst_uio_out", tt.uio_out, 8'h00);
    chk("rst_uio_oe", tt.uio_oe, 8'h07);
    rst_n = 1'b1;
    drive(0, 0, 0, 2'd3);
    chk("post_rst_state", tt.uo_out, 8'h00);
    bad = 1'b0;
    for (int i = 1; i <= 10000; i++) begin
      send(1, 0, 0, 0);
      if (i == 94) chk("clean_pre_lock", tt.uio_out[0], 1'b0);
      if (i == 95) chk("clean_lock", tt.uio_out[0], 1'b1);
      if (i > 95 && (tt.uio_out !== 8'h01 || tt.uo_out !== 8'h00)) bad = 1'b1;
    end
    chk("clean_stay_locked", bad, 1'b0);
    rd_err(e);
    chk("clean_err", e, 24'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_uio_out", tt.uio_out, 8'h00);
    chk("async_rst_uo", tt.uo_out, 8'h00);
    do_reset();
    nerr = 0;
    for (int i = 1; nerr < 95 && i < 400; i++) begin
      send(0, 0, 0, 0);
      send(1, 0, 0, 0);
      nerr++;
      if (nerr == 94) chk("gap_pre_lock", tt.uio_out[0], 1'b0);
      if (nerr == 95) chk("gap_lock", tt.uio_out[0], 1'b1);
    end
    rd_err(e);
    chk("gap_err", e, 24'h0);
    for (int i = 1; i < 200; i++) send(1, 0, 0, 0);
    send(1, 1, 0, 0);
    chk("inv_pulse", tt.uio_out[1], 1'b1);
    chk("inv_err", tt.uo_out, 8'h01);
    chk("inv_locked", tt.uio_out[0], 1'b1);
    send(1, 0, 0, 0);
    chk("inv_pulse_one_cycle", tt.uio_out[1], 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      send(1, 0, 0, 0);
      if (tt.uio_out !== 8'h01) bad = 1'b1;
    end
    chk("inv_no_propagation", bad, 1'b0);
    rd_err(e);
    chk("inv_err_total", e, 24'h1);
    for (int i = 0; i < 9; i++) begin
      send(vt[i].v, vt[i].inv, vt[i].clr, vt[i].sel);
      chk($sformatf("vec%0d_uo", i), tt.uo_out, vt[i].exp_uo);
      chk($sformatf("vec%0d_lock", i), tt.uio_out[0], vt[i].exp_lock);
      chk($sformatf("vec%0d_pulse", i), tt.uio_out[1], vt[i].exp_pulse);
    end
    do_reset();
    lock_clean("los");
    nerr = 0;
    for (int k = 1; k <= 64 && nerr < 16; k++) begin
      send(1, k % 4 == 0, 0, 0);
      if (k % 4 == 0) begin
        nerr++;
        if (nerr == 15) chk("los_15_locked", tt.uio_out[0], 1'b1);
        if (nerr == 16) chk("los_16_unlocked", tt.uio_out[0], 1'b0);
      end
    end
    rd(2'd3, d);
    chk("los_state_fill", d, 8'h00);
    rd_err(e);
    chk("los_err", e, 24'h10);
    lock_clean("relock");
    rd_err(e);
    chk("relock_err_kept", e, 24'h10);
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 500; i++) begin
      drive(1, 0, 0, 2'd3);
      if (tt.uio_out[0] !== 1'b0) bad = 1'b1;
    end
    chk("zero_never_locks", bad, 1'b0);
    chk("zero_state_hunt", tt.uo_out, 8'h01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
